// File: rtl/process_scheduler_if.sv
// rtl/process_scheduler_if.sv - admission and PC-restore handshake bundle for the process scheduler
interface process_scheduler_if #(
    parameter int PIDW = 3,
    parameter int AW   = 32
);
    logic            adm_valid;
    logic [PIDW-1:0] adm_pid;
    logic [AW-1:0]   adm_base;
    logic            adm_ready;
    logic            adm_err;
    logic            restore_valid;
    logic [AW-1:0]   restore_pc;

    modport master (
        output adm_valid, adm_pid, adm_base,
        input  adm_ready, adm_err, restore_valid, restore_pc
    );

    modport slave (
        input  adm_valid, adm_pid, adm_base,
        output adm_ready, adm_err, restore_valid, restore_pc
    );
endinterface

// File: rtl/process_scheduler.sv
// rtl/process_scheduler.sv - round-robin process table and context-switch sequencer
module process_scheduler #(
    parameter int NPROC = 8,
    parameter int PIDW  = 3,
    parameter int AW    = 32
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              enable,
    input  logic              quantum,
    input  logic              proc_halt,
    input  logic [AW-1:0]     save_pc,
    process_scheduler_if.slave bus,
    output logic              ctx,
    output logic [PIDW-1:0]   cur_pid,
    output logic [AW-1:0]     cur_base,
    output logic              idle,
    output logic [NPROC-1:0]  active_mask
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SAVE,
        S_SELECT,
        S_RESTORE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            kill;
    logic [AW-1:0]   pc_tab   [NPROC];
    logic [AW-1:0]   base_tab [NPROC];
    logic            adm_take;
    logic            adm_ok;
    logic            found;
    logic [PIDW-1:0] next_pid;
    logic [PIDW-1:0] idx;

    assign bus.adm_ready = (state == S_IDLE) || (state == S_RUN);
    assign adm_take      = bus.adm_valid && bus.adm_ready;
    assign adm_ok        = adm_take && !active_mask[bus.adm_pid];

    // Search starts after cur_pid and wraps around so cur_pid itself is tried last.
    always_comb begin
        found    = 1'b0;
        next_pid = cur_pid;
        idx      = '0;
        for (int i = 1; i <= NPROC; i++) begin
            idx = cur_pid + PIDW'(i);
            if (!found && active_mask[idx]) begin
                found    = 1'b1;
                next_pid = idx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (enable && (|active_mask)) state_nx = S_SELECT;
            S_RUN:     if (proc_halt || quantum) state_nx = S_SAVE;
            S_SAVE:    state_nx = S_SELECT;
            S_SELECT:  state_nx = found ? S_RESTORE : S_IDLE;
            S_RESTORE: state_nx = S_RUN;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            kill              <= 1'b0;
            active_mask       <= '0;
            cur_pid           <= PIDW'(NPROC - 1);
            cur_base          <= '0;
            bus.restore_pc    <= '0;
            bus.restore_valid <= 1'b0;
            bus.adm_err       <= 1'b0;
            ctx               <= 1'b0;
            idle              <= 1'b1;
        end else begin
            state             <= state_nx;
            ctx               <= (state_nx == S_SAVE) || (state_nx == S_SELECT) ||
                                 (state_nx == S_RESTORE);
            idle              <= (state_nx == S_IDLE);
            bus.restore_valid <= (state_nx == S_RESTORE);
            bus.adm_err       <= adm_take && active_mask[bus.adm_pid];

            // Halt takes priority over quantum; the flag decides kill-vs-save in SAVE.
            if (state == S_RUN && state_nx == S_SAVE)
                kill <= proc_halt;

            if (adm_ok)
                active_mask[bus.adm_pid] <= 1'b1;
            if (state == S_SAVE && kill)
                active_mask[cur_pid] <= 1'b0;

            if (state == S_SELECT && found) begin
                cur_pid        <= next_pid;
                bus.restore_pc <= pc_tab[next_pid];
                cur_base       <= base_tab[next_pid];
            end
        end
    end

    // Table contents are meaningless until a slot is admitted, so no reset.
    always_ff @(posedge CLK) begin
        if (adm_ok) begin
            base_tab[bus.adm_pid] <= bus.adm_base;
            pc_tab[bus.adm_pid]   <= bus.adm_base;
        end else if (state == S_SAVE && !kill) begin
            pc_tab[cur_pid] <= save_pc;
        end
    end

endmodule

// File: tb/tb_process_scheduler.sv
// tb/tb_process_scheduler.sv - randomized self-checking bench for process_scheduler
module tb_process_scheduler;
    localparam int NPROC = 8;
    localparam int PIDW  = 3;
    localparam int AW    = 32;

    logic             CLK = 1'b0;
    logic             reset;
    logic             enable;
    logic             quantum;
    logic             proc_halt;
    logic [AW-1:0]    save_pc;
    logic             ctx;
    logic [PIDW-1:0]  cur_pid;
    logic [AW-1:0]    cur_base;
    logic             idle;
    logic [NPROC-1:0] active_mask;

    process_scheduler_if #(.PIDW(PIDW), .AW(AW)) bus ();

    process_scheduler #(.NPROC(NPROC), .PIDW(PIDW), .AW(AW)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .enable      (enable),
        .quantum     (quantum),
        .proc_halt   (proc_halt),
        .save_pc     (save_pc),
        .bus         (bus),
        .ctx         (ctx),
        .cur_pid     (cur_pid),
        .cur_base    (cur_base),
        .idle        (idle),
        .active_mask (active_mask)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: process table plus the identity of the running slot.
    bit            mv    [NPROC];
    logic [AW-1:0] mpc   [NPROC];
    logic [AW-1:0] mbase [NPROC];
    int            mcur;
    bit            mrun;

    function automatic logic [NPROC-1:0] mmask();
        logic [NPROC-1:0] m;
        m = '0;
        for (int k = 0; k < NPROC; k++) m[k] = mv[k];
        return m;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < NPROC; k++) mv[k] = 1'b0;
        mcur = NPROC - 1;
        mrun = 1'b0;
    endfunction

    function automatic bit m_admit(input int pid, input logic [AW-1:0] b);
        if (mv[pid]) return 1'b1;
        mv[pid]    = 1'b1;
        mpc[pid]   = b;
        mbase[pid] = b;
        return 1'b0;
    endfunction

    function automatic int m_pick();
        for (int k = 1; k <= NPROC; k++)
            if (mv[(mcur + k) % NPROC]) return (mcur + k) % NPROC;
        return -1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; quantum = 1'b0; proc_halt = 1'b0; save_pc = '0;
        bus.adm_valid = 1'b0; bus.adm_pid = '0; bus.adm_base = '0;
        tick();
        tick();
        reset = 1'b0;
        m_reset();
        #1;
        check_eq("rst_idle", idle, 1);
        check_eq("rst_ctx", ctx, 0);
        check_eq("rst_mask", active_mask, 0);
        check_eq("rst_cur_pid", cur_pid, NPROC - 1);
        check_eq("rst_cur_base", cur_base, 0);
        check_eq("rst_restore_pc", bus.restore_pc, 0);
        check_eq("rst_restore_valid", bus.restore_valid, 0);
        check_eq("rst_adm_err", bus.adm_err, 0);
        check_eq("rst_adm_ready", bus.adm_ready, 1);
    endtask

    // Follows a switch from its first ctx cycle to the end and compares with the model.
    task automatic wait_switch(input int nxt, input int exp_ctx);
        int            n;
        int            rv;
        int            rpid;
        logic [AW-1:0] rpc;
        logic [AW-1:0] rbase;
        n = 0; rv = 0; rpid = 0; rpc = '0; rbase = '0;
        for (int c = 0; c < 12 && ctx; c++) begin
            n++;
            if (bus.restore_valid) begin
                rv++;
                rpc   = bus.restore_pc;
                rpid  = int'(cur_pid);
                rbase = cur_base;
            end
            tick();
            bus.adm_valid = 1'b0;
        end
        check_eq("ctx_cycles", n, exp_ctx);
        check_eq("restore_pulses", rv, (nxt >= 0) ? 1 : 0);
        check_eq("mask", active_mask, mmask());
        if (nxt >= 0) begin
            check_eq("restore_pc", rpc, mpc[nxt]);
            check_eq("restore_pid", rpid, nxt);
            check_eq("restore_base", rbase, mbase[nxt]);
            mcur = nxt;
            mrun = 1'b1;
            check_eq("run_not_idle", idle, 0);
            check_eq("hold_cur_base", cur_base, mbase[nxt]);
        end else begin
            mrun = 1'b0;
            check_eq("empty_idle", idle, 1);
            check_eq("empty_cur_pid", cur_pid, mcur);
        end
    endtask

    task automatic admit(input int pid, input logic [AW-1:0] b);
        bit exp_err;
        bus.adm_valid = 1'b1;
        bus.adm_pid   = pid[PIDW-1:0];
        bus.adm_base  = b;
        check_eq("adm_ready", bus.adm_ready, 1);
        exp_err = m_admit(pid, b);
        tick();
        bus.adm_valid = 1'b0;
        check_eq("adm_err", bus.adm_err, exp_err);
        check_eq("adm_mask", active_mask, mmask());
        if (exp_err) begin
            tick();
            check_eq("adm_err_pulse_end", bus.adm_err, 0);
        end
    endtask

    task automatic start();
        int nxt;
        enable = 1'b1;
        nxt = m_pick();
        tick();
        enable = 1'b0;
        if (nxt >= 0) begin
            wait_switch(nxt, 2);
        end else begin
            tick();
            check_eq("start_empty_idle", idle, 1);
            check_eq("start_empty_ctx", ctx, 0);
        end
    endtask

    task automatic run_switch(input bit h, input bit q, input logic [AW-1:0] spc,
                              input bit adm, input int apid, input logic [AW-1:0] abase,
                              input bit blk, input int bpid);
        bit exp_err;
        int nxt;
        exp_err = 1'b0;
        if (adm) begin
            bus.adm_valid = 1'b1;
            bus.adm_pid   = apid[PIDW-1:0];
            bus.adm_base  = abase;
            exp_err = m_admit(apid, abase);
        end
        proc_halt = h; quantum = q; save_pc = spc;
        if (h) mv[mcur] = 1'b0;
        else   mpc[mcur] = spc;
        nxt = m_pick();
        tick();
        proc_halt = 1'b0; quantum = 1'b0; bus.adm_valid = 1'b0;
        if (adm) check_eq("ev_adm_err", bus.adm_err, exp_err);
        if (blk) begin
            bus.adm_valid = 1'b1;
            bus.adm_pid   = bpid[PIDW-1:0];
            bus.adm_base  = $urandom;
            check_eq("adm_ready_save", bus.adm_ready, 0);
        end
        wait_switch(nxt, (nxt >= 0) ? 3 : 2);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int rv_seen;
        do_reset();

        admit(0, 32'h100);
        admit(2, 32'h400);
        start();
        check_eq("first_pid", cur_pid, 0);

        run_switch(0, 1, 32'h124, 0, 0, 0, 0, 0);
        run_switch(0, 1, 32'h408, 0, 0, 0, 0, 0);
        check_eq("rot_back_pid", cur_pid, 0);

        run_switch(1, 0, 32'hDEAD0, 0, 0, 0, 0, 0);
        check_eq("halt_mask", active_mask, 8'b0000_0100);
        run_switch(1, 0, 32'hDEAD4, 0, 0, 0, 0, 0);
        check_eq("all_halted_idle", idle, 1);

        admit(1, 32'h200);
        start();
        admit(3, 32'h300);
        run_switch(1, 1, 32'hBEEF, 0, 0, 0, 0, 0);
        check_eq("halt_wins_bit", active_mask[1], 0);

        admit(3, 32'h999);
        run_switch(0, 1, 32'h33C, 0, 0, 0, 1, 5);
        check_eq("blocked_adm_bit", active_mask[5], 0);
        run_switch(0, 1, 32'h350, 1, 6, 32'h600, 0, 0);

        quantum = 1'b1;
        tick();
        quantum = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check_eq("mid_rst_ctx", ctx, 0);
        check_eq("mid_rst_idle", idle, 1);
        check_eq("mid_rst_mask", active_mask, 0);
        check_eq("mid_rst_cur_pid", cur_pid, NPROC - 1);
        rv_seen = 0;
        for (int c = 0; c < 3; c++) begin
            if (bus.restore_valid) rv_seen++;
            tick();
        end
        reset = 1'b0;
        m_reset();
        for (int c = 0; c < 3; c++) begin
            if (bus.restore_valid) rv_seen++;
            tick();
        end
        check_eq("mid_rst_no_restore", rv_seen, 0);
        check_eq("post_rst_idle", idle, 1);

        for (int it = 0; it < 200; it++) begin
            int r;
            int p;
            logic [AW-1:0] b;
            r = int'($urandom_range(0, 99));
            p = int'($urandom_range(0, NPROC - 1));
            b = $urandom & 32'hFFFF_FFFC;
            if (!mrun) begin
                if (r < 60) admit(p, b);
                else        start();
            end else begin
                if (r < 25)      admit(p, b);
                else if (r < 55) run_switch(0, 1, b, 0, 0, 0, r[0], p);
                else if (r < 70) run_switch(1, 0, b, 0, 0, 0, r[0], p);
                else if (r < 80) run_switch(1, 1, b, 0, 0, 0, 0, 0);
                else             run_switch(r[0], 1, b, 1, p, $urandom & 32'hFFFF_FFFC, 0, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
